// File: rtl/crc16_arbiter_pkg.sv
// Shared types and constants for the CRC16 job arbiter.
//   state_e  : arbiter FSM states
//   req_id_e : requester identity (TX = requester 0, RX = requester 1)
//   CRC16_W  : width of the CRC result
package crc16_arbiter_pkg;

  localparam int CRC16_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    WAIT,
    RESP
  } state_e;

  typedef enum logic {
    REQ_TX,
    REQ_RX
  } req_id_e;

  function automatic req_id_e other_id(input req_id_e id);
    return (id == REQ_TX) ? REQ_RX : REQ_TX;
  endfunction

endpackage

// File: rtl/crc16_arbiter_if.sv
// Bundle of requester-side and engine-side signals of the CRC16 arbiter.
//   slave  : view of the arbiter itself
//   master : view of the surroundings (requesters + CRC engine)
// Requester side : tx/rx_req, tx/rx_data in; tx/rx_gnt, tx/rx_done, crc_out, crc_err out
// Engine side    : crc16_start, s_in, crc16_rec out; crc16_done, crc16_val in
interface crc16_arbiter_if #(
  parameter int DATA_W = 64
) ();
  import crc16_arbiter_pkg::*;

  logic              tx_req;
  logic              rx_req;
  logic [DATA_W-1:0] tx_data;
  logic [DATA_W-1:0] rx_data;
  logic              tx_gnt;
  logic              rx_gnt;
  logic              tx_done;
  logic              rx_done;
  logic [CRC16_W-1:0] crc_out;
  logic              crc_err;

  logic              crc16_start;
  logic              s_in;
  logic              crc16_done;
  logic [CRC16_W-1:0] crc16_val;
  logic              crc16_rec;

  modport slave (
    input  tx_req, rx_req, tx_data, rx_data, crc16_done, crc16_val,
    output tx_gnt, rx_gnt, tx_done, rx_done, crc_out, crc_err,
           crc16_start, s_in, crc16_rec
  );

  modport master (
    output tx_req, rx_req, tx_data, rx_data, crc16_done, crc16_val,
    input  tx_gnt, rx_gnt, tx_done, rx_done, crc_out, crc_err,
           crc16_start, s_in, crc16_rec
  );

endinterface

// File: rtl/crc16_arbiter_rr_pick.sv
// Two-way round-robin selector (purely combinational).
//   i_tx_req, i_rx_req : request pair
//   i_ptr              : requester favoured when both request
//   o_winner           : selected requester
//   o_valid            : at least one request present
module crc16_rr_pick
  import crc16_arbiter_pkg::*;
(
  input  logic    i_tx_req,
  input  logic    i_rx_req,
  input  req_id_e i_ptr,
  output req_id_e o_winner,
  output logic    o_valid
);

  always_comb begin
    o_valid  = i_tx_req | i_rx_req;
    o_winner = REQ_TX;
    if (i_tx_req && i_rx_req) begin
      o_winner = i_ptr;
    end else if (i_rx_req) begin
      o_winner = REQ_RX;
    end
  end

endmodule

// File: rtl/crc16_arbiter.sv
// Arbitrates two requesters (TX, RX) onto one external CRC16 engine.
// The winner's payload is serialized MSB first on s_in, then the engine
// result is awaited with a timeout and returned with a done pulse.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : crc16_arbiter_if.slave (requester and engine signals)
//
// state | meaning
// IDLE  | no job; grant the round-robin winner when any req is high
// SHIFT | payload bit on s_in each cycle, crc16_start on the first one
// WAIT  | waiting for crc16_done, bounded by TIMEOUT cycles
// RESP  | done pulse to owner, crc16_rec unless timed out, advance pointer
module crc16_arbiter
  import crc16_arbiter_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  crc16_arbiter_if.slave bus
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int TO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT);

  state_e              r_state;
  req_id_e             r_owner;
  req_id_e             r_ptr;
  logic [DATA_W-1:0]   r_shreg;
  logic [BIT_W-1:0]    r_bit_cnt;
  logic [TO_W-1:0]     r_to_cnt;
  logic                r_s_in;
  logic                r_start;
  logic                r_tx_done;
  logic                r_rx_done;
  logic                r_rec;
  logic [CRC16_W-1:0]  r_crc_out;
  logic                r_crc_err;

  req_id_e             w_winner;
  logic                w_valid;
  logic                w_grant;
  logic [DATA_W-1:0]   w_data;

  crc16_rr_pick u_pick (
    .i_tx_req (bus.tx_req),
    .i_rx_req (bus.rx_req),
    .i_ptr    (r_ptr),
    .o_winner (w_winner),
    .o_valid  (w_valid)
  );

  assign w_data = (w_winner == REQ_RX) ? bus.rx_data : bus.tx_data;

  // The grant has to appear in the same IDLE cycle the request is seen, so it
  // is decoded rather than registered; rst_n masks it while reset is held.
  assign w_grant = rst_n && (r_state == IDLE) && w_valid;

  assign bus.tx_gnt      = w_grant && (w_winner == REQ_TX);
  assign bus.rx_gnt      = w_grant && (w_winner == REQ_RX);
  assign bus.tx_done     = r_tx_done;
  assign bus.rx_done     = r_rx_done;
  assign bus.crc_out     = r_crc_out;
  assign bus.crc_err     = r_crc_err;
  assign bus.crc16_start = r_start;
  assign bus.s_in        = r_s_in;
  assign bus.crc16_rec   = r_rec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_owner   <= REQ_TX;
      r_ptr     <= REQ_TX;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_to_cnt  <= '0;
      r_s_in    <= 1'b0;
      r_start   <= 1'b0;
      r_tx_done <= 1'b0;
      r_rx_done <= 1'b0;
      r_rec     <= 1'b0;
      r_crc_out <= '0;
      r_crc_err <= 1'b0;
    end else begin
      r_start   <= 1'b0;
      r_tx_done <= 1'b0;
      r_rx_done <= 1'b0;
      r_rec     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            // The MSB goes straight to s_in; the register keeps the rest.
            r_owner   <= w_winner;
            r_s_in    <= w_data[DATA_W-1];
            r_shreg   <= {w_data[DATA_W-2:0], 1'b0};
            r_start   <= 1'b1;
            r_bit_cnt <= '0;
            r_state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (r_bit_cnt == BIT_LAST) begin
            r_s_in   <= 1'b0;
            r_to_cnt <= '0;
            r_state  <= WAIT;
          end else begin
            r_s_in    <= r_shreg[DATA_W-1];
            r_shreg   <= {r_shreg[DATA_W-2:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        WAIT: begin
          // An engine result in the same cycle as the timeout still wins.
          if (bus.crc16_done) begin
            r_crc_out <= bus.crc16_val;
            r_crc_err <= 1'b0;
            r_rec     <= 1'b1;
            r_tx_done <= (r_owner == REQ_TX);
            r_rx_done <= (r_owner == REQ_RX);
            r_state   <= RESP;
          end else if (r_to_cnt == TO_LAST) begin
            r_crc_out <= '0;
            r_crc_err <= 1'b1;
            r_tx_done <= (r_owner == REQ_TX);
            r_rx_done <= (r_owner == REQ_RX);
            r_state   <= RESP;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        RESP: begin
          r_ptr     <= other_id(r_owner);
          r_bit_cnt <= '0;
          r_to_cnt  <= '0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc16_arbiter.sv
module tb_crc16_arbiter;

  localparam int DW = 64;
  localparam int TO = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  crc16_arbiter_if #(.DATA_W(DW)) bus ();

  crc16_arbiter #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Event counters, serial capture and engine stub, all sampled mid-cycle.
  int tx_gnt_n = 0, rx_gnt_n = 0, tx_done_n = 0, rx_done_n = 0;
  int rec_n = 0, start_n = 0;
  int gnt_cyc = 0, start_cyc = 0, done_cyc = 0;
  int cap_pos = 0;
  bit cap_on = 1'b0;
  logic [DW-1:0] cap_data = '0;
  int stub_n = 3;
  int stub_cnt = 0;
  bit stub_wait = 1'b0;

  always @(negedge clk) begin
    bus.crc16_val = 16'h0323;
    if (!rst_n) begin
      bus.crc16_done = 1'b0;
      stub_wait      = 1'b0;
      cap_on         = 1'b0;
    end else begin
      if (bus.crc16_rec) bus.crc16_done = 1'b0;
      if (stub_wait) begin
        stub_cnt--;
        if (stub_cnt <= 0) begin
          bus.crc16_done = 1'b1;
          stub_wait      = 1'b0;
        end
      end
      if (bus.tx_gnt)  begin tx_gnt_n++;  gnt_cyc  = cyc; end
      if (bus.rx_gnt)  begin rx_gnt_n++;  gnt_cyc  = cyc; end
      if (bus.tx_done) begin tx_done_n++; done_cyc = cyc; end
      if (bus.rx_done) begin rx_done_n++; done_cyc = cyc; end
      if (bus.crc16_rec) rec_n++;
      if (bus.crc16_start) begin
        start_n++;
        start_cyc = cyc;
        cap_on    = 1'b1;
        cap_pos   = 0;
        cap_data  = '0;
      end
      if (cap_on) begin
        cap_data = {cap_data[DW-2:0], bus.s_in};
        if (cap_pos == DW - 1) begin
          cap_on = 1'b0;
          if (stub_n >= 0) begin
            stub_cnt  = stub_n;
            stub_wait = 1'b1;
          end
        end
        cap_pos++;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic at_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  // which: 0 tx_gnt, 1 rx_gnt, 2 tx_done, 3 rx_done
  task automatic wait_ev(input string tag, input int which, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      at_neg();
      case (which)
        0:       seen = bus.tx_gnt;
        1:       seen = bus.rx_gnt;
        2:       seen = bus.tx_done;
        default: seen = bus.rx_done;
      endcase
    end
    chk(tag, 64'(seen), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int rec0, st0, grx0, rxd0, gsum0;

    bus.tx_req  = 1'b0;
    bus.rx_req  = 1'b0;
    bus.tx_data = '0;
    bus.rx_data = '0;

    // Reset state
    repeat (3) at_neg();
    chk("rst crc_out", 64'(bus.crc_out), 64'h0);
    chk("rst crc_err", 64'(bus.crc_err), 64'h0);
    chk("rst pulses", 64'({bus.tx_done, bus.rx_done, bus.crc16_start, bus.s_in, bus.crc16_rec}), 64'h0);
    bus.tx_req = 1'b1;
    #1;
    chk("rst tx_gnt masked", 64'(bus.tx_gnt), 64'h0);
    bus.tx_req = 1'b0;
    at_neg();
    rst_n = 1'b1;

    // A: single TX job; data changed and rx_req toggled after the grant
    stub_n = 3;
    at_pos();
    bus.tx_data = 64'h0000_0000_0000_D500;
    bus.tx_req  = 1'b1;
    wait_ev("A tx_gnt", 0, 2);
    grx0 = rx_gnt_n;
    rec0 = rec_n;
    st0  = start_n;
    at_pos();
    bus.tx_data = '1;
    for (int i = 0; i < 10; i++) begin
      at_pos();
      bus.rx_req = ~bus.rx_req;
    end
    bus.rx_req = 1'b0;
    wait_ev("A tx_done", 2, 150);
    chk("A crc_out", 64'(bus.crc_out), 64'h0323);
    chk("A crc_err", 64'(bus.crc_err), 64'h0);
    chk("A crc16_rec with done", 64'(bus.crc16_rec), 64'h1);
    chk("A s_in stream", cap_data, 64'h0000_0000_0000_D500);
    chk("A start count", 64'(start_n - st0), 64'd1);
    chk("A first bit latency", 64'(start_cyc - gnt_cyc), 64'd1);
    chk("A done latency", 64'(done_cyc - gnt_cyc), 64'd68);
    chk("A no rx_gnt during job", 64'(rx_gnt_n - grx0), 64'd0);
    bus.tx_req = 1'b0;
    at_neg();
    at_neg();
    chk("A rec count", 64'(rec_n - rec0), 64'd1);

    // B: both request from reset -> TX, RX, then TX again
    at_neg();
    rst_n = 1'b0;
    repeat (3) at_neg();
    rst_n = 1'b1;
    stub_n = 1;
    at_pos();
    bus.tx_data = 64'h8000_0000_0000_0001;
    bus.rx_data = 64'h1234_5678_9ABC_DEF0;
    bus.tx_req  = 1'b1;
    bus.rx_req  = 1'b1;
    wait_ev("B tx_gnt first", 0, 2);
    chk("B rx_gnt held off", 64'(bus.rx_gnt), 64'h0);
    wait_ev("B tx_done", 2, 150);
    chk("B tx stream", cap_data, 64'h8000_0000_0000_0001);
    chk("B tx done latency", 64'(done_cyc - gnt_cyc), 64'd66);
    wait_ev("B rx_gnt after tx_done", 1, 1);
    chk("B tx_gnt loses", 64'(bus.tx_gnt), 64'h0);
    wait_ev("B rx_done", 3, 150);
    chk("B rx stream", cap_data, 64'h1234_5678_9ABC_DEF0);
    chk("B rx crc_out", 64'(bus.crc_out), 64'h0323);
    wait_ev("B tx regrant", 0, 1);
    at_pos();
    bus.tx_req = 1'b0;
    bus.rx_req = 1'b0;
    wait_ev("B tx second done", 2, 150);
    chk("B second tx stream", cap_data, 64'h8000_0000_0000_0001);

    // E: reset at bit 30 of an RX job
    stub_n = 3;
    at_pos();
    bus.rx_data = 64'hA5A5_A5A5_A5A5_A5A5;
    bus.rx_req  = 1'b1;
    wait_ev("E rx_gnt", 1, 2);
    rxd0 = rx_done_n;
    for (int i = 0; i < 60 && cap_pos != 31; i++) at_neg();
    chk("E reached bit 30", 64'(cap_pos), 64'd31);
    rst_n = 1'b0;
    #1;
    chk("E rst crc_out", 64'(bus.crc_out), 64'h0);
    chk("E rst s_in/start/rec", 64'({bus.s_in, bus.crc16_start, bus.crc16_rec}), 64'h0);
    chk("E rst rx_gnt", 64'(bus.rx_gnt), 64'h0);
    bus.rx_req = 1'b0;
    gsum0 = tx_gnt_n + rx_gnt_n;
    repeat (2) at_neg();
    rst_n = 1'b1;
    repeat (90) at_neg();
    chk("E no rx_done", 64'(rx_done_n - rxd0), 64'd0);
    chk("E no spurious gnt", 64'(tx_gnt_n + rx_gnt_n - gsum0), 64'd0);
    at_pos();
    bus.tx_data = 64'h0F0F_0000_FFFF_1234;
    bus.tx_req  = 1'b1;
    wait_ev("E tx_gnt after reset", 0, 2);
    wait_ev("E tx_done", 2, 150);
    chk("E tx stream", cap_data, 64'h0F0F_0000_FFFF_1234);
    chk("E crc_out", 64'(bus.crc_out), 64'h0323);
    bus.tx_req = 1'b0;

    // D: engine never answers -> timeout
    stub_n = -1;
    at_pos();
    bus.tx_data = 64'h0000_0000_0000_0001;
    bus.tx_req  = 1'b1;
    wait_ev("D tx_gnt", 0, 3);
    rec0 = rec_n;
    wait_ev("D tx_done", 2, 200);
    chk("D done latency", 64'(done_cyc - gnt_cyc), 64'd82);
    chk("D crc_err", 64'(bus.crc_err), 64'h1);
    chk("D crc_out", 64'(bus.crc_out), 64'h0);
    chk("D no crc16_rec", 64'(bus.crc16_rec), 64'h0);
    bus.tx_req = 1'b0;
    at_neg();
    at_neg();
    chk("D rec count", 64'(rec_n - rec0), 64'd0);
    chk("D crc_err held", 64'(bus.crc_err), 64'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
